// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared saturating-arithmetic helpers for the adder tree
//
// Purpose: clamp limits, the saturating add used at every tree node and the
//          accumulator, the tree depth helper, and the sideband beat record.
// Ports:   none (package).
package sat_pkg;

  // Arithmetic is done at a fixed wide width, so one function serves any
  // lane width up to 63 bits without overflowing the intermediate sum.
  localparam int SAT_WIDE = 64;

  typedef logic signed [SAT_WIDE-1:0] sat_wide_t;

  typedef struct packed {
    logic      flag;
    sat_wide_t value;
  } sat_res_t;

  // Control bits that travel down the tree alongside each beat.
  typedef struct packed {
    logic valid;
    logic mode;
    logic first;
    logic last;
  } sideband_t;

  function automatic sat_wide_t sat_max(input int width);
    return (sat_wide_t'(1) <<< (width - 1)) - sat_wide_t'(1);
  endfunction

  function automatic sat_wide_t sat_min(input int width);
    return -sat_max(width) - sat_wide_t'(1);
  endfunction

  function automatic int sat_levels(input int n);
    return $clog2(n);
  endfunction

  // Operands arrive sign-extended, so the exact sum always fits in the wide
  // type; out-of-range sums are exactly the two-operand overflow cases.
  function automatic sat_res_t sat_add(input sat_wide_t a, input sat_wide_t b,
                                       input int width);
    sat_wide_t s;
    sat_res_t  r;
    s = a + b;
    if (s > sat_max(width)) begin
      r.flag  = 1'b1;
      r.value = sat_max(width);
    end else if (s < sat_min(width)) begin
      r.flag  = 1'b1;
      r.value = sat_min(width);
    end else begin
      r.flag  = 1'b0;
      r.value = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_add_stage.sv
// rtl/sat_add_stage.sv - one registered saturating two-input adder with flags
//
// Purpose: r = sat_add(a, b); flag = clamp | a_flag | b_flag, registered.
// Ports:   i_clock, i_reset_n (async, active low), i_enable (hold when 0),
//          i_a/i_b + i_a_flag/i_b_flag operands, o_sum/o_flag registered result.
module sat_add_stage
  import sat_pkg::*;
#(
  parameter int data_width = 17
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_enable,
  input  logic signed [data_width-1:0] i_a,
  input  logic signed [data_width-1:0] i_b,
  input  logic                         i_a_flag,
  input  logic                         i_b_flag,
  output logic signed [data_width-1:0] o_sum,
  output logic                         o_flag
);

  sat_res_t                     w_res;
  logic signed [data_width-1:0] r_sum;
  logic                         r_flag;

  assign w_res = sat_add(sat_wide_t'(i_a), sat_wide_t'(i_b), data_width);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sum  <= '0;
      r_flag <= 1'b0;
    end else if (i_enable) begin
      r_sum  <= w_res.value[data_width-1:0];
      r_flag <= w_res.flag | i_a_flag | i_b_flag;
    end
  end

  assign o_sum  = r_sum;
  assign o_flag = r_flag;

endmodule

// File: rtl/sat_adder_tree.sv
// rtl/sat_adder_tree.sv - pipelined saturating adder tree with accumulator
//
// Purpose: reduces num_inputs signed lanes to one saturated sum per beat,
//          optionally accumulating successive beats (in_mode=1).
// Ports:   clock, reset (async, active low), enable (global stall),
//          in_valid/in_mode/in_first/in_last beat controls, data_in packed
//          lanes; sum/saturated result, out_valid qualifier.
module sat_adder_tree
  import sat_pkg::*;
#(
  parameter int data_width = 17,
  parameter int num_inputs = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             in_valid,
  input  logic                             in_mode,
  input  logic                             in_first,
  input  logic                             in_last,
  input  logic [num_inputs*data_width-1:0] data_in,
  output logic signed [data_width-1:0]     sum,
  output logic                             out_valid,
  output logic                             saturated
);

  localparam int LEVELS = sat_levels(num_inputs);

  // Heap layout: node g combines 2g and 2g+1, leaves sit at num_inputs..,
  // the root is node 1. All leaves share one depth, so every path through
  // the tree carries the same number of registers.
  logic signed [data_width-1:0] w_node [1:2*num_inputs-1];
  logic                         w_flag [1:2*num_inputs-1];

  genvar g;
  for (g = 0; g < num_inputs; g++) begin : g_leaf
    assign w_node[num_inputs+g] = data_in[g*data_width +: data_width];
    assign w_flag[num_inputs+g] = 1'b0;
  end

  for (g = 1; g < num_inputs; g++) begin : g_node
    sat_add_stage #(.data_width(data_width)) u_stage (
      .i_clock  (clock),
      .i_reset_n(reset),
      .i_enable (enable),
      .i_a      (w_node[2*g]),
      .i_b      (w_node[2*g+1]),
      .i_a_flag (w_flag[2*g]),
      .i_b_flag (w_flag[2*g+1]),
      .o_sum    (w_node[g]),
      .o_flag   (w_flag[g])
    );
  end

  sideband_t r_sb [1:LEVELS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= LEVELS; k++) r_sb[k] <= '0;
    end else if (enable) begin
      r_sb[1] <= '{valid: in_valid, mode: in_mode, first: in_first, last: in_last};
      for (int k = 2; k <= LEVELS; k++) r_sb[k] <= r_sb[k-1];
    end
  end

  sideband_t                    w_tree_sb;
  logic signed [data_width-1:0] w_acc;
  logic                         w_acc_flag;
  logic signed [data_width-1:0] w_acc_a;
  logic                         w_acc_a_flag;
  logic                         w_acc_en;

  assign w_tree_sb    = r_sb[LEVELS];
  // A first beat starts from zero instead of the stale accumulator.
  assign w_acc_a      = w_tree_sb.first ? '0 : w_acc;
  assign w_acc_a_flag = ~w_tree_sb.first & w_acc_flag;
  assign w_acc_en     = enable & w_tree_sb.valid & w_tree_sb.mode;

  sat_add_stage #(.data_width(data_width)) u_acc (
    .i_clock  (clock),
    .i_reset_n(reset),
    .i_enable (w_acc_en),
    .i_a      (w_acc_a),
    .i_b      (w_node[1]),
    .i_a_flag (w_acc_a_flag),
    .i_b_flag (w_flag[1]),
    .o_sum    (w_acc),
    .o_flag   (w_acc_flag)
  );

  // The visible result is either the pass-through register or the
  // accumulator itself (r_sel_acc). When an accumulating beat would alter
  // the accumulator while it is on display, the displayed value is first
  // copied into the pass-through register so sum keeps holding.
  logic                         r_out_valid;
  logic signed [data_width-1:0] r_pass_sum;
  logic                         r_pass_flag;
  logic                         r_sel_acc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_pass_sum  <= '0;
      r_pass_flag <= 1'b0;
      r_sel_acc   <= 1'b0;
    end else if (enable) begin
      r_out_valid <= w_tree_sb.valid & (~w_tree_sb.mode | w_tree_sb.last);
      if (w_tree_sb.valid && !w_tree_sb.mode) begin
        r_pass_sum  <= w_node[1];
        r_pass_flag <= w_flag[1];
        r_sel_acc   <= 1'b0;
      end else if (w_tree_sb.valid && w_tree_sb.last) begin
        r_sel_acc   <= 1'b1;
      end else if (w_tree_sb.valid && r_sel_acc) begin
        r_pass_sum  <= w_acc;
        r_pass_flag <= w_acc_flag;
        r_sel_acc   <= 1'b0;
      end
    end
  end

  // Gating with enable hides a held result during a stall; it reappears on
  // the next enabled cycle, so nothing is dropped or duplicated.
  assign out_valid = r_out_valid & enable;
  assign sum       = r_sel_acc ? w_acc : r_pass_sum;
  assign saturated = r_sel_acc ? w_acc_flag : r_pass_flag;

endmodule

// File: tb/tb_sat_adder_tree.sv
// tb/tb_sat_adder_tree.sv - directed self-checking bench for sat_adder_tree
module tb_sat_adder_tree;

  localparam int DW = 17;
  localparam int NI = 8;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 enable = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_mode = 1'b0;
  logic                 in_first = 1'b0;
  logic                 in_last = 1'b0;
  logic [NI*DW-1:0]     data_in = '0;
  logic signed [DW-1:0] sum;
  logic                 out_valid;
  logic                 saturated;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  sat_adder_tree #(.data_width(DW), .num_inputs(NI)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .in_valid (in_valid),
    .in_mode  (in_mode),
    .in_first (in_first),
    .in_last  (in_last),
    .data_in  (data_in),
    .sum      (sum),
    .out_valid(out_valid),
    .saturated(saturated)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int i, input int v);
    data_in[i*DW +: DW] = v[DW-1:0];
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NI; i++) set_lane(i, v);
  endtask

  task automatic drive(input logic mode, input logic first, input logic last);
    in_valid = 1'b1;
    in_mode  = mode;
    in_first = first;
    in_last  = last;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_mode  = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Presents the lanes already loaded as one mode-0 beat, then watches a
  // bounded window and reports the first result and how many appeared.
  task automatic run_single(output int hit, output int cnt, output int s, output logic f);
    hit = -1;
    cnt = 0;
    s   = 0;
    f   = 1'b0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc == 0) drive(1'b0, 1'b0, 1'b0);
      else idle();
      #1;
      if (out_valid) begin
        cnt++;
        if (hit < 0) begin
          hit = cyc;
          s   = int'(sum);
          f   = saturated;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (int'(sum) !== 0) begin bad++; $display("FAIL reset_sum got=%0d want=0", int'(sum)); end
    total++; if (saturated !== 1'b0) begin bad++; $display("FAIL reset_saturated got=%b want=0", saturated); end
    tick();
    tick();
    reset  = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_pass_basic();
    int hit, cnt, s;
    logic f;
    for (int i = 0; i < NI; i++) set_lane(i, i + 1);
    run_single(hit, cnt, s, f);
    total++; if (hit !== 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", hit); end
    total++; if (cnt !== 1) begin bad++; $display("FAIL basic_count got=%0d want=1", cnt); end
    total++; if (s !== 36) begin bad++; $display("FAIL basic_sum got=%0d want=36", s); end
    total++; if (f !== 1'b0) begin bad++; $display("FAIL basic_sat got=%b want=0", f); end
    total++; if (int'(sum) !== 36) begin bad++; $display("FAIL basic_hold got=%0d want=36", int'(sum)); end
  endtask

  task automatic test_saturation();
    int hit, cnt, s;
    logic f;
    set_all(30000);
    run_single(hit, cnt, s, f);
    total++; if (s !== 65535 || hit !== 4) begin bad++; $display("FAIL sat_pos_sum got=%0d@%0d want=65535@4", s, hit); end
    total++; if (f !== 1'b1) begin bad++; $display("FAIL sat_pos_flag got=%b want=1", f); end
    set_all(-20000);
    run_single(hit, cnt, s, f);
    total++; if (s !== -65536 || hit !== 4) begin bad++; $display("FAIL sat_neg_sum got=%0d@%0d want=-65536@4", s, hit); end
    total++; if (f !== 1'b1) begin bad++; $display("FAIL sat_neg_flag got=%b want=1", f); end
  endtask

  task automatic test_cancel();
    int hit, cnt, s;
    logic f;
    for (int i = 0; i < NI; i++) set_lane(i, (i % 2 == 0) ? 65535 : -65535);
    run_single(hit, cnt, s, f);
    total++; if (s !== 0 || hit !== 4) begin bad++; $display("FAIL cancel_sum got=%0d@%0d want=0@4", s, hit); end
    total++; if (f !== 1'b0) begin bad++; $display("FAIL cancel_flag got=%b want=0", f); end
  endtask

  task automatic test_accumulate();
    int hit = -1;
    int cnt = 0;
    int s = 0;
    logic f = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 3) begin
        set_all(1);
        drive(1'b1, cyc == 0, cyc == 2);
      end else idle();
      #1;
      if (out_valid) begin
        cnt++;
        hit = cyc;
        s   = int'(sum);
        f   = saturated;
      end
      tick();
    end
    total++; if (cnt !== 1) begin bad++; $display("FAIL acc_count got=%0d want=1", cnt); end
    total++; if (hit !== 6) begin bad++; $display("FAIL acc_cycle got=%0d want=6", hit); end
    total++; if (s !== 24) begin bad++; $display("FAIL acc_sum got=%0d want=24", s); end
    total++; if (f !== 1'b0) begin bad++; $display("FAIL acc_flag got=%b want=0", f); end
  endtask

  task automatic test_stall();
    int exp_cyc [6] = '{4, 7, 8, 9, 10, 11};
    int got_sum [6];
    int got_cyc [6];
    int b = 0;
    int n = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      enable = !(cyc == 5 || cyc == 6);
      if (enable && b < 6) begin
        set_all(b + 1);
        drive(1'b0, 1'b0, 1'b0);
        b++;
      end else idle();
      #1;
      if (!enable) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_gate cyc=%0d got=%b want=0", cyc, out_valid); end
      end
      if (out_valid) begin
        if (n < 6) begin
          got_sum[n] = int'(sum);
          got_cyc[n] = cyc;
        end
        n++;
      end
      tick();
    end
    enable = 1'b1;
    total++; if (n !== 6) begin bad++; $display("FAIL stall_count got=%0d want=6", n); end
    for (int k = 0; k < 6 && k < n; k++) begin
      total++;
      if (got_sum[k] !== 8 * (k + 1) || got_cyc[k] !== exp_cyc[k]) begin
        bad++;
        $display("FAIL stall_result k=%0d got=%0d@%0d want=%0d@%0d", k, got_sum[k], got_cyc[k], 8 * (k + 1), exp_cyc[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int hit = -1;
    int cnt = 0;
    int s = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc < 2) begin
        set_all(5);
        drive(1'b1, cyc == 0, 1'b0);
      end else idle();
      tick();
    end
    total++; if (int'(sum) !== 48) begin bad++; $display("FAIL rstmid_before got=%0d want=48", int'(sum)); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (int'(sum) !== 0) begin bad++; $display("FAIL rstmid_sum got=%0d want=0", int'(sum)); end
    total++; if (out_valid !== 1'b0 || saturated !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got=%b%b want=00", out_valid, saturated); end
    tick();
    reset = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 0) begin
        set_all(2);
        drive(1'b1, 1'b1, 1'b1);
      end else idle();
      #1;
      if (out_valid) begin
        cnt++;
        if (hit < 0) begin
          hit = cyc;
          s   = int'(sum);
        end
      end
      tick();
    end
    total++; if (cnt !== 1 || hit !== 4) begin bad++; $display("FAIL rstmid_count got=%0d@%0d want=1@4", cnt, hit); end
    total++; if (s !== 16) begin bad++; $display("FAIL rstmid_result got=%0d want=16", s); end
  endtask

  initial begin
    test_reset();
    test_pass_basic();
    test_saturation();
    test_cancel();
    test_accumulate();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
